// File: rtl/blit_src_fetch.sv
// blit_src_fetch: walks a source rectangle in raster order, one byte read
// per pixel, and re-forms the returned bytes into a tagged pixel stream.
module blit_src_fetch #(
    parameter int FIFO_DEPTH = 2,
    parameter int DIM_W      = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [15:0]      src_stride,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic             busy,
    output logic             done,
    output logic [31:0]      read_address,
    output logic             read_request,
    input  logic [7:0]       read_data,
    input  logic             read_stall,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [7:0]       pix_data,
    output logic [DIM_W-1:0] pix_x,
    output logic [DIM_W-1:0] pix_y,
    output logic             pix_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [7:0]       data;
        logic [DIM_W-1:0] x;
        logic [DIM_W-1:0] y;
        logic             last;
    } ent_t;

    localparam logic [2:0]       CREDITS = 3'(FIFO_DEPTH);
    localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);

    state_t           state, state_nx;
    logic [15:0]      stride_q;
    logic [DIM_W-1:0] width_q, height_q;
    logic [31:0]      row_base;
    logic [DIM_W-1:0] x, y;
    logic             in_flight;
    logic [DIM_W-1:0] tag_x, tag_y;
    logic             tag_last;
    ent_t             mem [FIFO_DEPTH];
    ent_t             head;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic [2:0]       used;
    logic             credit_ok, last_pix, accept, push, pop;

    // Credits count both buffered entries and the read whose byte is still due.
    assign used      = {1'b0, count} + {2'b00, in_flight};
    assign credit_ok = used < CREDITS;
    assign last_pix  = (x == width_q - ONE) && (y == height_q - ONE);
    assign accept    = read_request && !read_stall;
    assign push      = in_flight;
    assign pix_valid = count != 2'd0;
    assign pop       = pix_valid && pix_ready;

    assign read_address = row_base + {{(32-DIM_W){1'b0}}, x};

    assign head     = mem[rd_ptr];
    assign pix_data = head.data;
    assign pix_x    = head.x;
    assign pix_y    = head.y;
    assign pix_last = head.last;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        read_request = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (width == '0 || height == '0) ? FINISH : RUN;
            end
            RUN: begin
                busy         = 1'b1;
                read_request = credit_ok;
                if (credit_ok && !read_stall && last_pix)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!in_flight && (count == 2'd0 || (count == 2'd1 && pop)))
                    state_nx = FINISH;
            end
            FINISH: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Job fields latch on start; raster walker advances on each accepted read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stride_q <= '0;
            width_q  <= '0;
            height_q <= '0;
            row_base <= '0;
            x        <= '0;
            y        <= '0;
        end else if (state == IDLE && start) begin
            stride_q <= src_stride;
            width_q  <= width;
            height_q <= height;
            row_base <= src_addr;
            x        <= '0;
            y        <= '0;
        end else if (accept) begin
            if (x == width_q - ONE) begin
                x        <= '0;
                y        <= y + ONE;
                row_base <= row_base + {{16{stride_q[15]}}, stride_q};
            end else begin
                x <= x + ONE;
            end
        end
    end

    // Tag of the accepted read travels one cycle behind it with its data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight <= 1'b0;
            tag_x     <= '0;
            tag_y     <= '0;
            tag_last  <= 1'b0;
        end else begin
            in_flight <= accept;
            if (accept) begin
                tag_x    <= x;
                tag_y    <= y;
                tag_last <= last_pix;
            end
        end
    end

    // Skid FIFO: returning bytes are always captured; credits keep it from overflowing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {read_data, tag_x, tag_y, tag_last};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (!push && pop) count <= count - 2'd1;
        end
    end
endmodule

// File: tb/tb_blit_src_fetch.sv
// tb_blit_src_fetch: table of jobs plus random jobs, checked cycle by cycle
// against a transaction-level model of the expected read and pixel streams.
module tb_blit_src_fetch;
    localparam int DW = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   src_addr;
    logic [15:0]   src_stride;
    logic [DW-1:0] width, height;
    logic          busy, done;
    logic [31:0]   read_address;
    logic          read_request;
    logic [7:0]    read_data;
    logic          read_stall;
    logic          pix_valid, pix_ready;
    logic [7:0]    pix_data;
    logic [DW-1:0] pix_x, pix_y;
    logic          pix_last;

    blit_src_fetch #(.FIFO_DEPTH(2), .DIM_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .src_stride(src_stride),
        .width(width), .height(height),
        .busy(busy), .done(done),
        .read_address(read_address), .read_request(read_request),
        .read_data(read_data), .read_stall(read_stall),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_last(pix_last)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]   src;
        logic [15:0]   stride;
        logic [DW-1:0] w, h;
        int            sm, rm;
        int            np;
        logic [31:0]   last;
    } vec_t;

    vec_t vt[9];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr[$];
    int          npix, acc_total, popped, w_cur;
    bit          busy_exp, done_exp, acc_prev, prev_stall_req;
    logic [31:0] acc_addr_prev, prev_addr;
    int          smode, rmode, stall_cnt, hold_cnt;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_clear();
        busy_exp = 0; done_exp = 0; acc_prev = 0; prev_stall_req = 0;
        acc_total = 0; popped = 0; npix = 0; w_cur = 1;
        exp_addr.delete();
    endtask

    task automatic check_zero(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_read_request"}, read_request, 0);
        chk({p, "_read_address"}, read_address, 0);
        chk({p, "_pix_valid"}, pix_valid, 0);
        chk({p, "_pix_data"}, pix_data, 0);
        chk({p, "_pix_x"}, pix_x, 0);
        chk({p, "_pix_y"}, pix_y, 0);
        chk({p, "_pix_last"}, pix_last, 0);
    endtask

    // One clock: drive inputs and check outputs at the falling edge.
    task automatic step(input bit st, input logic [31:0] sa,
                        input logic [15:0] ss, input logic [DW-1:0] w,
                        input logic [DW-1:0] h);
        bit          exp_req, pop, accept, cur_busy;
        int          fifo_n;
        logic [31:0] rb;
        @(negedge clock);
        read_data = acc_prev ? mem_byte(acc_addr_prev) : 8'($urandom);
        case (rmode)
            1: pix_ready = $urandom_range(0, 99) < 70;
            2: begin
                pix_ready = !(popped >= 2 && hold_cnt < 10);
                if (!pix_ready) hold_cnt++;
            end
            default: pix_ready = 1'b1;
        endcase
        exp_req = busy_exp && !done_exp && acc_total < npix &&
                  (acc_total - popped) < 2;
        fifo_n  = acc_total - int'(acc_prev) - popped;
        chk("busy", busy, busy_exp);
        chk("done", done, done_exp);
        chk("read_request", read_request, exp_req);
        chk("pix_valid", pix_valid, fifo_n > 0);
        if (prev_stall_req) begin
            chk("stall_hold_req", read_request, 1);
            chk("stall_hold_addr", read_address, prev_addr);
        end
        if (read_request && acc_total < npix)
            chk("read_address", read_address, exp_addr[acc_total]);
        pop = pix_valid && pix_ready;
        if (pop) begin
            if (popped < npix) begin
                chk("pix_data", pix_data, mem_byte(exp_addr[popped]));
                chk("pix_x", pix_x, popped % w_cur);
                chk("pix_y", pix_y, popped / w_cur);
                chk("pix_last", pix_last, popped == npix - 1);
            end else begin
                checks++;
                errors++;
                $display("FAIL extra_pixel actual=%h required=none", pix_data);
            end
        end
        case (smode)
            1: read_stall = $urandom_range(0, 99) < 30;
            2: begin
                read_stall = read_request && acc_total == 1 && stall_cnt < 4;
                if (read_stall) stall_cnt++;
            end
            default: read_stall = 1'b0;
        endcase
        accept         = read_request && !read_stall;
        prev_stall_req = read_request && read_stall;
        prev_addr      = read_address;
        acc_prev       = accept;
        if (accept) begin
            acc_addr_prev = read_address;
            acc_total++;
        end
        cur_busy = busy_exp;
        if (pop) popped++;
        if (done_exp) begin
            busy_exp = 0;
            done_exp = 0;
        end else if (pop && popped == npix) begin
            done_exp = 1;
        end
        start = st;
        if (st) begin
            src_addr = sa; src_stride = ss; width = w; height = h;
        end else begin
            src_addr = $urandom; src_stride = 16'($urandom);
            width = DW'($urandom); height = DW'($urandom);
        end
        if (st && !cur_busy) begin
            exp_addr.delete();
            rb = sa;
            for (int yy = 0; yy < int'(h); yy++) begin
                for (int xx = 0; xx < int'(w); xx++) exp_addr.push_back(rb + xx);
                rb = rb + {{16{ss[15]}}, ss};
            end
            npix = int'(w) * int'(h);
            w_cur = (w == 0) ? 1 : int'(w);
            acc_total = 0; popped = 0; acc_prev = 0; prev_stall_req = 0;
            busy_exp = 1;
            done_exp = (npix == 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_clear();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_job(input logic [31:0] sa, input logic [15:0] ss,
                           input logic [DW-1:0] w, input logic [DW-1:0] h,
                           input int sm, input int rm, input int np,
                           input logic [31:0] la);
        smode = sm; rmode = rm; stall_cnt = 0; hold_cnt = 0;
        step(1, sa, ss, w, h);
        for (int c = 0; c < np * 30 + 40 && busy_exp; c++) idle(1);
        chk("pixel_count", popped, np);
        chk("read_count", acc_total, np);
        if (np > 0) chk("last_read_address", acc_addr_prev, la);
        if (busy_exp) begin
            checks++;
            errors++;
            $display("FAIL job_timeout actual=busy required=done src=%h", sa);
            do_reset();
        end
        idle(2);
    endtask

    initial begin
        vt[0] = '{32'h0000_1000, 16'h0100, 12'd3, 12'd2, 0, 0, 6, 32'h0000_1102};
        vt[1] = '{32'h0000_1000, 16'h0100, 12'd3, 12'd2, 2, 0, 6, 32'h0000_1102};
        vt[2] = '{32'h0000_2000, 16'h0040, 12'd4, 12'd4, 0, 2, 16, 32'h0000_20C3};
        vt[3] = '{32'h0000_0080, 16'hFF00, 12'd1, 12'd2, 0, 0, 2, 32'hFFFF_FF80};
        vt[4] = '{32'h0000_7000, 16'h0010, 12'd0, 12'd5, 0, 0, 0, 32'h0};
        vt[5] = '{32'h0000_7000, 16'h0010, 12'd3, 12'd0, 0, 0, 0, 32'h0};
        vt[6] = '{32'hFFFF_FFFE, 16'h0010, 12'd4, 12'd1, 1, 1, 4, 32'h0000_0001};
        vt[7] = '{32'h1234_5678, 16'hFFF0, 12'd5, 12'd3, 1, 1, 15, 32'h1234_565C};
        vt[8] = '{32'hABCD_0000, 16'h0000, 12'd1, 12'd1, 1, 1, 1, 32'hABCD_0000};

        reset = 1'b0; start = 1'b0; pix_ready = 1'b1; read_stall = 1'b0;
        read_data = '0; src_addr = '0; src_stride = '0; width = '0; height = '0;
        smode = 0; rmode = 0;
        model_clear();
        #3;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        idle(2);

        for (int i = 0; i < 9; i++)
            run_job(vt[i].src, vt[i].stride, vt[i].w, vt[i].h,
                    vt[i].sm, vt[i].rm, vt[i].np, vt[i].last);

        // start while busy must be ignored
        smode = 0; rmode = 0;
        step(1, 32'h0000_3000, 16'h0010, 12'd3, 12'd3);
        idle(3);
        step(1, 32'h0000_9000, 16'h0001, 12'd7, 12'd7);
        for (int c = 0; c < 200 && busy_exp; c++) idle(1);
        chk("ignored_start_count", popped, 9);
        chk("ignored_start_last", acc_addr_prev, 32'h0000_3022);
        idle(2);

        // reset mid-job aborts at once, then a clean job runs
        smode = 1; rmode = 1;
        step(1, 32'h0000_4000, 16'h0020, 12'd4, 12'd4);
        idle(8);
        #2 reset = 1'b0;
        #1 check_zero("async_rst");
        model_clear();
        idle(3);
        reset = 1'b1;
        run_job(32'h0000_5000, 16'h0100, 12'd2, 12'd2, 0, 0, 4, 32'h0000_5101);

        for (int i = 0; i < 8; i++) begin
            logic [31:0]   sa;
            logic [15:0]   ss;
            logic [DW-1:0] w, h;
            sa = $urandom;
            ss = 16'($urandom);
            w  = DW'($urandom_range(1, 6));
            h  = DW'($urandom_range(1, 4));
            run_job(sa, ss, w, h, 1, 1, int'(w) * int'(h),
                    sa + 32'(h - 1) * {{16{ss[15]}}, ss} + 32'(w - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
